// File: rtl/axislv2noc.sv
// AXI4 read-only slave that turns CPU read bursts into NoC coherence-request packets
// and streams the memory tile's response flits back onto the AXI R channel.
module axislv2noc #(
   parameter logic [4:0] MSG_AXI_RD = 5'b00100,
   parameter int         MAX_LEN    = 256
) (
   input  logic        ACLK,
   input  logic        ARESET,
   input  logic [2:0]  local_y,
   input  logic [2:0]  local_x,
   input  logic [2:0]  dst_y,
   input  logic [2:0]  dst_x,
   input  logic        AR_ID,
   input  logic        AR_VALID,
   output logic        AR_READY,
   input  logic [31:0] AR_ADDR,
   input  logic [7:0]  AR_LEN,
   input  logic [2:0]  AR_SIZE,
   input  logic [1:0]  AR_BURST,
   input  logic [2:0]  AR_PROT,
   output logic        R_ID,
   output logic        R_VALID,
   input  logic        R_READY,
   output logic [31:0] R_DATA,
   output logic [1:0]  R_RESP,
   output logic        R_LAST,
   output logic        coherence_req_wrreq,
   output logic [33:0] coherence_req_data_in,
   input  logic        coherence_req_full,
   output logic        coherence_rsp_rcv_rdreq,
   input  logic [33:0] coherence_rsp_rcv_data_out,
   input  logic        coherence_rsp_rcv_empty
);

   localparam int         BEAT_W   = $clog2(MAX_LEN);
   localparam logic [1:0] PRE_HDR  = 2'b10;
   localparam logic [1:0] PRE_BODY = 2'b00;
   localparam logic [1:0] PRE_TAIL = 2'b01;
   localparam logic [1:0] RESP_OK  = 2'b00;
   localparam logic [1:0] RESP_ERR = 2'b10;

   typedef enum logic [2:0] {
      IDLE,
      SEND_HEADER,
      SEND_ADDRESS,
      SEND_LENGTH,
      WAIT_HEADER,
      RETURN_DATA,
      ERR_RESP
   } state_t;

   state_t state, next_state;

   logic              id_q;
   logic [31:0]       addr_q;
   logic [BEAT_W-1:0] len_q;
   logic [2:0]        prot_q;
   logic [BEAT_W-1:0] beat;

   logic              ar_err;
   logic              last_beat;
   logic [1:0]        rsp_pre;
   logic [7:0]        len_field;
   logic [33:0]       header_flit;

   // Only INCR bursts of up to 32-bit beats can be serviced by the memory tile.
   assign ar_err    = (AR_BURST != 2'b01) || (AR_SIZE > 3'd2);
   assign last_beat = (beat == len_q);
   assign rsp_pre   = coherence_rsp_rcv_data_out[33:32];
   // A 256-beat burst wraps to 8'h00 in the length field; the memory tile decodes it that way.
   assign len_field = 8'(len_q) + 8'd1;
   assign header_flit = {PRE_HDR, local_y, local_x, dst_y, dst_x, MSG_AXI_RD,
                         5'b00000, prot_q, 7'b0000000};

   always_ff @(posedge ACLK or posedge ARESET) begin
      if (ARESET) begin
         state  <= IDLE;
         id_q   <= 1'b0;
         addr_q <= '0;
         len_q  <= '0;
         prot_q <= '0;
         beat   <= '0;
      end else begin
         state <= next_state;
         if (state == IDLE && AR_VALID) begin
            id_q   <= AR_ID;
            addr_q <= AR_ADDR;
            len_q  <= AR_LEN[BEAT_W-1:0];
            prot_q <= AR_PROT;
            beat   <= '0;
         end else if (state == WAIT_HEADER) begin
            beat <= '0;
         end else if ((state == RETURN_DATA && coherence_rsp_rcv_rdreq) ||
                      (state == ERR_RESP && R_READY)) begin
            beat <= beat + BEAT_W'(1);
         end
      end
   end

   always_comb begin
      next_state              = state;
      AR_READY                = 1'b0;
      R_ID                    = 1'b0;
      R_VALID                 = 1'b0;
      R_DATA                  = '0;
      R_RESP                  = RESP_OK;
      R_LAST                  = 1'b0;
      coherence_req_wrreq     = 1'b0;
      coherence_req_data_in   = '0;
      coherence_rsp_rcv_rdreq = 1'b0;
      case (state)
         IDLE: begin
            AR_READY = 1'b1;
            if (AR_VALID) next_state = ar_err ? ERR_RESP : SEND_HEADER;
         end
         SEND_HEADER: begin
            coherence_req_wrreq   = !coherence_req_full;
            coherence_req_data_in = header_flit;
            if (!coherence_req_full) next_state = SEND_ADDRESS;
         end
         SEND_ADDRESS: begin
            coherence_req_wrreq   = !coherence_req_full;
            coherence_req_data_in = {PRE_BODY, addr_q};
            if (!coherence_req_full) next_state = SEND_LENGTH;
         end
         SEND_LENGTH: begin
            coherence_req_wrreq   = !coherence_req_full;
            coherence_req_data_in = {PRE_TAIL, 24'h000000, len_field};
            if (!coherence_req_full) next_state = WAIT_HEADER;
         end
         WAIT_HEADER: begin
            // Anything ahead of a header is left over from an aborted transfer and is dropped.
            coherence_rsp_rcv_rdreq = !coherence_rsp_rcv_empty;
            if (!coherence_rsp_rcv_empty && rsp_pre == PRE_HDR) next_state = RETURN_DATA;
         end
         RETURN_DATA: begin
            R_VALID = !coherence_rsp_rcv_empty;
            R_DATA  = coherence_rsp_rcv_data_out[31:0];
            R_ID    = id_q;
            R_LAST  = last_beat;
            if (last_beat ? (rsp_pre != PRE_TAIL) : (rsp_pre == PRE_TAIL)) R_RESP = RESP_ERR;
            coherence_rsp_rcv_rdreq = !coherence_rsp_rcv_empty && R_READY;
            if (coherence_rsp_rcv_rdreq) begin
               if (last_beat)                  next_state = IDLE;
               else if (rsp_pre == PRE_TAIL)   next_state = ERR_RESP;
            end
         end
         ERR_RESP: begin
            R_VALID = 1'b1;
            R_ID    = id_q;
            R_RESP  = RESP_ERR;
            R_LAST  = last_beat;
            if (R_READY && last_beat) next_state = IDLE;
         end
         default: next_state = IDLE;
      endcase
   end

endmodule

// File: tb/tb_axislv2noc.sv
// Table-driven scoreboard bench for axislv2noc: models the request/response NoC queues
// and checks every pushed request flit and every R beat against expectations.
module tb_axislv2noc;

   logic        ACLK = 1'b0;
   logic        ARESET;
   logic [2:0]  local_y, local_x, dst_y, dst_x;
   logic        AR_ID, AR_VALID, AR_READY;
   logic [31:0] AR_ADDR;
   logic [7:0]  AR_LEN;
   logic [2:0]  AR_SIZE;
   logic [1:0]  AR_BURST;
   logic [2:0]  AR_PROT;
   logic        R_ID, R_VALID, R_READY;
   logic [31:0] R_DATA;
   logic [1:0]  R_RESP;
   logic        R_LAST;
   logic        coherence_req_wrreq;
   logic [33:0] coherence_req_data_in;
   logic        coherence_req_full;
   logic        coherence_rsp_rcv_rdreq;
   logic [33:0] coherence_rsp_rcv_data_out;
   logic        coherence_rsp_rcv_empty;

   axislv2noc dut (
      .ACLK(ACLK), .ARESET(ARESET),
      .local_y(local_y), .local_x(local_x), .dst_y(dst_y), .dst_x(dst_x),
      .AR_ID(AR_ID), .AR_VALID(AR_VALID), .AR_READY(AR_READY), .AR_ADDR(AR_ADDR),
      .AR_LEN(AR_LEN), .AR_SIZE(AR_SIZE), .AR_BURST(AR_BURST), .AR_PROT(AR_PROT),
      .R_ID(R_ID), .R_VALID(R_VALID), .R_READY(R_READY), .R_DATA(R_DATA),
      .R_RESP(R_RESP), .R_LAST(R_LAST),
      .coherence_req_wrreq(coherence_req_wrreq),
      .coherence_req_data_in(coherence_req_data_in),
      .coherence_req_full(coherence_req_full),
      .coherence_rsp_rcv_rdreq(coherence_rsp_rcv_rdreq),
      .coherence_rsp_rcv_data_out(coherence_rsp_rcv_data_out),
      .coherence_rsp_rcv_empty(coherence_rsp_rcv_empty)
   );

   always #5 ACLK = ~ACLK;

   typedef struct {
      logic [33:0] flit;
      int          exp_tick;
   } req_t;

   typedef struct {
      logic [31:0] addr;
      logic [7:0]  len;
      logic [1:0]  burst;
      logic [2:0]  size;
      logic [2:0]  prot;
      logic        id;
      logic [11:0] coords;
      int          mode;
      int          tail_at;
      int          stall;
      bit          toggle;
      int          stale;
      logic [31:0] seed;
      bit          exp_err;
   } vec_t;

   req_t        req_exp[$];
   logic [35:0] r_exp[$];
   logic [33:0] rsp_q[$];
   int          n_checks = 0;
   int          n_pass   = 0;
   int          cyc      = 0;
   int          hs_tick  = 0;
   int          n_push   = 0;
   vec_t        vecs[10];

   task automatic check(string name, logic [63:0] act, logic [63:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
   endtask

   task automatic fail(string name, logic [63:0] act, logic [63:0] exp);
      n_checks++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
   endtask

   task automatic refreshRsp();
      coherence_rsp_rcv_empty    = (rsp_q.size() == 0);
      coherence_rsp_rcv_data_out = (rsp_q.size() == 0) ? 34'h0 : rsp_q[0];
   endtask

   // One clock: observe at the falling edge, then model the response FIFO pop after the rising edge.
   task automatic tick();
      req_t e;
      logic [35:0] rb;
      logic do_pop;
      @(negedge ACLK);
      cyc++;
      if (coherence_req_wrreq) begin
         if (coherence_req_full) fail("wrreq_while_full", 1, 0);
         else if (req_exp.size() == 0) fail("unexpected_push", coherence_req_data_in, 0);
         else begin
            e = req_exp.pop_front();
            check("req_flit", coherence_req_data_in, e.flit);
            if (e.exp_tick >= 0) check("req_timing", cyc - hs_tick, e.exp_tick);
            n_push++;
         end
      end
      if (R_VALID && R_READY) begin
         if (r_exp.size() == 0) fail("unexpected_rbeat", {R_ID, R_DATA, R_RESP, R_LAST}, 0);
         else begin
            rb = r_exp.pop_front();
            check("rbeat", {R_ID, R_DATA, R_RESP, R_LAST}, rb);
         end
      end
      do_pop = coherence_rsp_rcv_rdreq && (rsp_q.size() > 0);
      @(posedge ACLK);
      #1;
      if (do_pop) void'(rsp_q.pop_front());
      refreshRsp();
   endtask

   function automatic vec_t mkVec(logic [31:0] addr, logic [7:0] len, logic [1:0] burst,
                                  logic [2:0] size, logic [2:0] prot, logic id,
                                  logic [11:0] coords, int mode, int tail_at, int stall,
                                  bit toggle, int stale, logic [31:0] seed, bit exp_err);
      vec_t v;
      v.addr = addr; v.len = len; v.burst = burst; v.size = size; v.prot = prot; v.id = id;
      v.coords = coords; v.mode = mode; v.tail_at = tail_at; v.stall = stall;
      v.toggle = toggle; v.stale = stale; v.seed = seed; v.exp_err = exp_err;
      return v;
   endfunction

   task automatic applyStimulus(vec_t v);
      logic [7:0]  lp1;
      logic [31:0] d;
      logic [1:0]  pre;
      int          nflits;
      int          budget;
      n_push  = 0;
      local_y = v.coords[11:9];
      local_x = v.coords[8:6];
      dst_y   = v.coords[5:3];
      dst_x   = v.coords[2:0];
      lp1     = v.len + 8'd1;
      if (!v.exp_err) begin
         req_exp.push_back('{{2'b10, v.coords, 5'b00100, 5'b00000, v.prot, 7'b0}, 1});
         req_exp.push_back('{{2'b00, v.addr}, (v.stall == 0) ? 2 : -1});
         req_exp.push_back('{{2'b01, 24'h0, lp1}, (v.stall == 0) ? 3 : -1});
         for (int j = 0; j < v.stale; j++) rsp_q.push_back({2'b00, 32'hDEAD_0000 + j});
         rsp_q.push_back({2'b10, 32'h0BAD_0001});
         nflits = (v.mode == 1) ? v.tail_at + 1 : int'(v.len) + 1;
         for (int i = 0; i < nflits; i++) begin
            d = 32'h11 * (i + 1) + v.seed;
            if (v.mode == 1)      pre = (i == v.tail_at) ? 2'b01 : 2'b00;
            else if (v.mode == 2) pre = 2'b00;
            else                  pre = (i == int'(v.len)) ? 2'b01 : 2'b00;
            rsp_q.push_back({pre, d});
         end
      end
      for (int i = 0; i <= int'(v.len); i++) begin
         d = 32'h11 * (i + 1) + v.seed;
         if (v.exp_err)
            r_exp.push_back({v.id, 32'h0, 2'b10, i == int'(v.len)});
         else if (v.mode == 1 && i > v.tail_at)
            r_exp.push_back({v.id, 32'h0, 2'b10, i == int'(v.len)});
         else if (v.mode == 1 && i == v.tail_at)
            r_exp.push_back({v.id, d, 2'b10, 1'b0});
         else if (v.mode == 2 && i == int'(v.len))
            r_exp.push_back({v.id, d, 2'b10, 1'b1});
         else
            r_exp.push_back({v.id, d, 2'b00, i == int'(v.len)});
      end
      refreshRsp();
      AR_VALID = 1'b1; AR_ID = v.id; AR_ADDR = v.addr; AR_LEN = v.len;
      AR_SIZE = v.size; AR_BURST = v.burst; AR_PROT = v.prot;
      budget = 50;
      while (!AR_READY && budget > 0) begin
         tick();
         budget--;
      end
      if (budget == 0) fail("ar_handshake_timeout", 0, 1);
      tick();
      hs_tick  = cyc;
      AR_VALID = 1'b0; AR_ADDR = '0; AR_LEN = '0; AR_PROT = '0; AR_ID = 1'b0;
      AR_BURST = 2'b01; AR_SIZE = 3'd2;
   endtask

   task automatic checkOutput(vec_t v);
      int budget;
      int stall_left;
      budget     = 2000;
      stall_left = v.stall;
      while ((req_exp.size() != 0 || r_exp.size() != 0) && budget > 0) begin
         if (n_push == 1 && stall_left > 0) begin
            coherence_req_full = 1'b1;
            stall_left--;
         end else begin
            coherence_req_full = 1'b0;
         end
         R_READY = v.toggle ? cyc[0] : 1'b1;
         tick();
         budget--;
      end
      if (budget == 0) fail("txn_timeout", req_exp.size() + r_exp.size(), 0);
      coherence_req_full = 1'b0;
      R_READY = 1'b1;
      check("ar_ready_after", AR_READY, 1);
      check("rsp_drained", rsp_q.size(), 0);
      req_exp.delete();
      r_exp.delete();
   endtask

   initial begin
      int budget;
      ARESET = 1'b1;
      local_y = 0; local_x = 0; dst_y = 0; dst_x = 0;
      AR_ID = 0; AR_VALID = 0; AR_ADDR = 0; AR_LEN = 0; AR_SIZE = 3'd2; AR_BURST = 2'b01;
      AR_PROT = 0; R_READY = 1'b1; coherence_req_full = 1'b0;
      refreshRsp();

      vecs[0] = mkVec(32'h8000_1000, 8'd7,   2'b01, 3'd2, 3'b010, 1'b0, {3'd1,3'd2,3'd0,3'd0}, 0, 0, 0, 0, 0, 32'h0,        0);
      vecs[1] = mkVec(32'h0000_0040, 8'd3,   2'b01, 3'd2, 3'b101, 1'b1, {3'd1,3'd2,3'd0,3'd0}, 0, 0, 5, 0, 0, 32'h0100_0000, 0);
      vecs[2] = mkVec(32'h1234_5678, 8'd5,   2'b01, 3'd1, 3'b000, 1'b1, {3'd7,3'd5,3'd3,3'd6}, 0, 0, 0, 1, 0, 32'h0200_0000, 0);
      vecs[3] = mkVec(32'h0000_2000, 8'd7,   2'b01, 3'd2, 3'b001, 1'b0, {3'd1,3'd2,3'd0,3'd0}, 1, 3, 0, 0, 0, 32'h0300_0000, 0);
      vecs[4] = mkVec(32'h0000_3000, 8'd7,   2'b01, 3'd2, 3'b000, 1'b1, {3'd1,3'd2,3'd0,3'd0}, 2, 0, 0, 0, 0, 32'h0400_0000, 0);
      vecs[5] = mkVec(32'h0000_4000, 8'd3,   2'b10, 3'd2, 3'b000, 1'b1, {3'd1,3'd2,3'd0,3'd0}, 0, 0, 0, 0, 0, 32'h0,        1);
      vecs[6] = mkVec(32'h0000_5000, 8'd0,   2'b01, 3'd3, 3'b000, 1'b0, {3'd1,3'd2,3'd0,3'd0}, 0, 0, 0, 0, 0, 32'h0,        1);
      vecs[7] = mkVec(32'h0000_6000, 8'd0,   2'b01, 3'd0, 3'b111, 1'b1, {3'd2,3'd3,3'd4,3'd5}, 0, 0, 0, 0, 0, 32'h0700_0000, 0);
      vecs[8] = mkVec(32'h0000_7000, 8'd2,   2'b01, 3'd2, 3'b000, 1'b0, {3'd1,3'd2,3'd0,3'd0}, 0, 0, 0, 0, 2, 32'h0800_0000, 0);
      vecs[9] = mkVec(32'hFFFF_FF00, 8'd255, 2'b01, 3'd2, 3'b100, 1'b1, {3'd0,3'd1,3'd6,3'd7}, 0, 0, 0, 0, 0, 32'h0900_0000, 0);

      repeat (2) @(posedge ACLK);
      #1;
      check("rst_ar_ready", AR_READY, 1);
      check("rst_r_valid", R_VALID, 0);
      check("rst_wrreq", coherence_req_wrreq, 0);
      check("rst_rdreq", coherence_rsp_rcv_rdreq, 0);
      check("rst_r_last", R_LAST, 0);
      check("rst_req_data", coherence_req_data_in, 0);
      ARESET = 1'b0;

      // Reset in the middle of a data return; the leftover flits must be purged by the next read.
      applyStimulus(mkVec(32'h0000_9000, 8'd7, 2'b01, 3'd2, 3'b000, 1'b1,
                          {3'd1,3'd2,3'd0,3'd0}, 0, 0, 0, 0, 0, 32'h0A00_0000, 0));
      budget = 200;
      while (r_exp.size() > 5 && budget > 0) begin
         tick();
         budget--;
      end
      if (budget == 0) fail("midrst_timeout", r_exp.size(), 5);
      ARESET = 1'b1;
      #1;
      check("midrst_ar_ready", AR_READY, 1);
      check("midrst_r_valid", R_VALID, 0);
      check("midrst_wrreq", coherence_req_wrreq, 0);
      req_exp.delete();
      r_exp.delete();
      @(posedge ACLK);
      #1;
      ARESET = 1'b0;

      for (int i = 0; i < 10; i++) begin
         applyStimulus(vecs[i]);
         checkOutput(vecs[i]);
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
